// File: rtl/serial_and_frame_reducer.sv
// Serial bitwise-AND frame reducer: ANDs operand beats until in_last, then holds the result.
// Optional SERIAL_AND_FRAME_OVF_EN: saturating beat count with sticky overflow flag.
module serial_and_frame_reducer_mux (
  input  logic d0_i,
  input  logic d1_i,
  input  logic sel_i,
  output logic y_o
);
  assign y_o = sel_i ? d1_i : d0_i;
endmodule

module serial_and_frame_reducer #(
  parameter  int WIDTH     = 8,
  parameter  int MAX_BEATS = 15,
  localparam int CW        = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_beats,
  output logic             out_zero,
  output logic             out_ovf
);

  typedef enum logic {ACC, HOLD} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, acc_upd;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_upd;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    beats_q, beats_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] prod;

  for (genvar i = 0; i < WIDTH; i++) begin : g_mux
    serial_and_frame_reducer_mux u_mux (
      .d0_i  (1'b0),
      .d1_i  (in_a[i]),
      .sel_i (in_b[i]),
      .y_o   (prod[i])
    );
  end

  assign acc_upd = acc_q & prod;

`ifdef SERIAL_AND_FRAME_OVF_EN
  localparam logic [CW-1:0] MAXC = CW'(MAX_BEATS);
  logic ovf_q, ovf_d, ovf_upd;
  logic oovf_q, oovf_d;
  assign cnt_upd  = (cnt_q == MAXC) ? cnt_q : cnt_q + CW'(1);
  assign ovf_upd  = ovf_q | (cnt_q == MAXC);
  assign out_ovf  = oovf_q;
`else
  assign cnt_upd  = cnt_q + CW'(1);
  assign out_ovf  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    beats_d = beats_q;
    zero_d  = zero_q;
`ifdef SERIAL_AND_FRAME_OVF_EN
    ovf_d   = ovf_q;
    oovf_d  = oovf_q;
`endif
    unique case (state_q)
      ACC: begin
        if (in_valid) begin
          acc_d = acc_upd;
          cnt_d = cnt_upd;
`ifdef SERIAL_AND_FRAME_OVF_EN
          ovf_d = ovf_upd;
`endif
          if (in_last) begin
            data_d  = acc_upd;
            beats_d = cnt_upd;
            zero_d  = (acc_upd == '0);
            state_d = HOLD;
            acc_d   = '1;
            cnt_d   = '0;
`ifdef SERIAL_AND_FRAME_OVF_EN
            oovf_d  = ovf_upd;
            ovf_d   = 1'b0;
`endif
          end
        end
      end
      HOLD: begin
        if (out_ready) state_d = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      acc_q   <= '1;
      cnt_q   <= '0;
      data_q  <= '0;
      beats_q <= '0;
      zero_q  <= 1'b0;
`ifdef SERIAL_AND_FRAME_OVF_EN
      ovf_q   <= 1'b0;
      oovf_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      beats_q <= beats_d;
      zero_q  <= zero_d;
`ifdef SERIAL_AND_FRAME_OVF_EN
      ovf_q   <= ovf_d;
      oovf_q  <= oovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == HOLD);
  assign out_data  = data_q;
  assign out_beats = beats_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_serial_and_frame_reducer.sv
// Scoreboard bench for serial_and_frame_reducer (directed frames, decoupled monitor).
// Expected overflow behaviour follows SERIAL_AND_FRAME_OVF_EN.
module tb_serial_and_frame_reducer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_last;
  logic [7:0] in_a, in_b;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic [3:0] out_beats;
  logic       out_zero, out_ovf;

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] b;
    logic       z;
    logic       o;
  } exp_t;

  exp_t sb[$];
  int   n_tot  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  serial_and_frame_reducer #(.WIDTH(8), .MAX_BEATS(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_beats (out_beats),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: compares every presented result against the queue head.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        chk("out_data", {24'd0, out_data}, {24'd0, sb[0].d});
        chk("out_beats", {28'd0, out_beats}, {28'd0, sb[0].b});
        chk("out_zero", {31'd0, out_zero}, {31'd0, sb[0].z});
        chk("out_ovf", {31'd0, out_ovf}, {31'd0, sb[0].o});
        chk("in_ready_hold", {31'd0, in_ready}, 32'd0);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic last);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = 8'h00;
    in_b      = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b1;
    idle(2);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_beats", {28'd0, out_beats}, 32'd0);
    chk("rst_out_zero", {31'd0, out_zero}, 32'd0);
    chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    rst_n = 1'b1;
    idle(1);
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // single-beat frame, latency 1
    sb.push_back('{d: 8'h30, b: 4'd1, z: 1'b0, o: 1'b0});
    send(8'hF0, 8'h3C, 1'b1);
    chk("t1_latency", {31'd0, out_valid}, 32'd1);
    idle(2);

    // three beats with an idle gap carrying junk
    sb.push_back('{d: 8'h0E, b: 4'd3, z: 1'b0, o: 1'b0});
    send(8'hFF, 8'hFF, 1'b0);
    in_a = 8'h00; in_b = 8'h00; in_last = 1'b1;
    idle(1);
    in_last = 1'b0;
    send(8'h0F, 8'hFF, 1'b0);
    send(8'hFF, 8'h0E, 1'b1);
    chk("t2_valid", {31'd0, out_valid}, 32'd1);
    idle(1);
    chk("t2_valid_one_cycle", {31'd0, out_valid}, 32'd0);
    chk("t2_ready_back", {31'd0, in_ready}, 32'd1);
    idle(1);

    // backpressure; junk beats offered while holding
    out_ready = 1'b0;
    sb.push_back('{d: 8'h50, b: 4'd1, z: 1'b0, o: 1'b0});
    send(8'h5A, 8'hF0, 1'b1);
    in_valid = 1'b1; in_a = 8'h00; in_b = 8'h00; in_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_ready_low", {31'd0, in_ready}, 32'd0);
      idle(1);
    end
    out_ready = 1'b1;
    idle(1);
    in_valid = 1'b0; in_last = 1'b0;
    chk("t3_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("t3_ready_back", {31'd0, in_ready}, 32'd1);
    idle(1);

    // zero result
    sb.push_back('{d: 8'h00, b: 4'd2, z: 1'b1, o: 1'b0});
    send(8'hAA, 8'hFF, 1'b0);
    send(8'h55, 8'hFF, 1'b1);
    idle(2);

    // reset mid-frame discards partial frame
    send(8'h12, 8'h34, 1'b0);
    send(8'h56, 8'h78, 1'b0);
    rst_n = 1'b0;
    #3;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    sb.push_back('{d: 8'hC3, b: 4'd1, z: 1'b0, o: 1'b0});
    send(8'hC3, 8'hFF, 1'b1);
    chk("t5_valid", {31'd0, out_valid}, 32'd1);
    idle(2);

    // 17-beat frame: overflow behaviour
`ifdef SERIAL_AND_FRAME_OVF_EN
    sb.push_back('{d: 8'hFF, b: 4'd15, z: 1'b0, o: 1'b1});
`else
    sb.push_back('{d: 8'hFF, b: 4'd1, z: 1'b0, o: 1'b0});
`endif
    for (int i = 0; i < 17; i++) send(8'hFF, 8'hFF, i == 16);
    idle(1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
    chk("sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/serial_and_frame_reducer.md
SERIAL_AND_FRAME_REDUCER -- requirements
Module: serial_and_frame_reducer

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each operand beat.
REQ-002 Parameter MAX_BEATS, default 15: largest beat count per frame; CW = $clog2(MAX_BEATS+1).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream beat present.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 in_a  input  WIDTH  operand A.
REQ-008 in_b  input  WIDTH  operand B.
REQ-009 in_last  input  1  beat closes the current frame.
REQ-010 out_valid  output  1  frame result held.
REQ-011 out_ready  input  1  downstream takes the result.
REQ-012 out_data  output  WIDTH  bitwise AND of every in_a and in_b bit in the frame.
REQ-013 out_beats  output  CW  number of beats in the frame, including the last beat.
REQ-014 out_zero  output  1  out_data == 0.
REQ-015 out_ovf  output  1  frame exceeded MAX_BEATS; this port is always present.

Function
REQ-016 The per-beat product in_a & in_b SHALL be built from WIDTH instances of the team mux cell, each with d0=0, d1=in_a[i], sel=in_b[i].
REQ-017 The FSM SHALL have two states: ACC, which accumulates, and HOLD, which presents the result.
REQ-018 in_ready SHALL be 1 in ACC and 0 in HOLD.
REQ-019 A beat SHALL be accepted when in_valid && in_ready; no other cycle changes the accumulator.
REQ-020 On each accepted beat, acc SHALL become acc & in_a & in_b and cnt SHALL become cnt+1.
REQ-021 An accepted beat with in_last=1 SHALL load out_data, out_beats and out_zero from the updated values and move the FSM to HOLD.
REQ-022 out_valid SHALL rise one cycle after the last beat is accepted; latency is 1 cycle.
REQ-023 Entering HOLD SHALL re-initialise acc to all-ones and cnt to 0.
REQ-024 In HOLD, out_valid=1 and out_data, out_beats, out_zero and out_ovf SHALL stay stable until out_valid && out_ready.
REQ-025 On handshake the FSM SHALL return to ACC with out_valid=0 next cycle.
REQ-026 No beat is accepted in the handshake cycle.
REQ-027 A single-beat frame, with in_last on the first beat, SHALL give out_data = in_a & in_b and out_beats = 1.
REQ-028 in_valid=0 in ACC SHALL leave all state unchanged; idle gaps mid-frame are legal.
REQ-029 in_a, in_b and in_last SHALL be ignored when the beat is not accepted.

Reset
REQ-030 Asserting rst_n=0 SHALL immediately force the FSM to ACC, acc to all-ones, cnt to 0, and out_valid, out_data, out_beats, out_zero and out_ovf to 0.
REQ-031 Reset mid-frame or in HOLD SHALL discard the partial frame or held result with no output.
REQ-032 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-033 Macro SERIAL_AND_FRAME_OVF_EN defined: cnt SHALL saturate at MAX_BEATS, and a sticky flag SHALL set when a beat is accepted with cnt==MAX_BEATS.
REQ-034 With the macro defined, out_ovf SHALL carry that flag for the frame; the flag clears on entering HOLD.
REQ-035 Macro not defined: cnt SHALL wrap modulo 2^CW and out_ovf SHALL be constant 0.

Verification
REQ-036 Reset, then one beat a=8'hF0, b=8'h3C, last=1 -> next cycle out_valid=1, out_data=8'h30, out_beats=1, out_zero=0.
REQ-037 Three beats (FF,FF), (0F,FF) with an idle gap, then (FF,0E) last, with out_ready=1 -> out_data=8'h0E, out_beats=3, out_valid for exactly 1 cycle.
REQ-038 Frame completes with out_ready=0 for 4 cycles -> in_ready=0 and outputs stable throughout; after out_ready=1, in_ready=1 next cycle.
REQ-039 Two beats (AA,FF) then (55,FF) last -> out_data=0, out_zero=1.
REQ-040 rst_n pulsed low after 2 beats of a frame, then a 1-beat frame (C3,FF) -> out_data=8'hC3, out_beats=1, no earlier out_valid.
REQ-041 MAX_BEATS=15 with 17 beats of (FF,FF) -> with SERIAL_AND_FRAME_OVF_EN: out_beats=15, out_ovf=1; without it: out_beats=1 (wrapped), out_ovf=0.
